bus_select_arbiter: RTL and testbench
=====================================

Name: bus_select_arbiter

Overview:
Round-robin arbiter and strobe sequencer for the shared peripheral-select decode (3-to-8, active-low outputs).
- Up to four requesters (CPU, sound CPU, DMA/sprite copier, debug port) each present a 3-bit region index.
- The block grants one requester at a time and drives a timed active-low chip-select on the selected region.
- It acknowledges completion, replacing free-running decode with setup/strobe/recovery timing.

Parameters:
NREQ, 4, number of requesters (2..4); unused upper req bits are ignored.
HOLD, 2, strobe width in clk cycles (1..15).

Ports:
clk      in   1   system clock, all logic on rising edge
reset    in   1   synchronous, active-high reset
en       in   1   global enable (decoder G1 equivalent); low blocks/aborts strobes
req      in   4   request per requester, level, held until ack
sel      in   12  region index per requester; requester i uses sel[3i+2:3i]
grant    out  4   one-hot current owner, registered
cs_n     out  8   active-low region selects; at most one bit low
ack      out  4   one-cycle completion pulse to owner
busy     out  1   high whenever state != IDLE

Behaviour:
- Reset values (synchronous, sampled at the clk edge with reset=1; reset overrides everything, including mid-strobe):
  - state=IDLE, grant=0, cs_n=8'hFF, ack=0, busy=0, rr pointer=0.
- State machine, registered outputs, one transition per clk:
  - IDLE:
    - If en=1 and any req[i] (i<NREQ): choose the first asserted index scanning from ptr upward, mod NREQ.
    - Latch owner and region=sel of owner, set grant[owner]=1, go SETUP.
    - Otherwise stay in IDLE.
  - SETUP (1 cycle):
    - grant held, cs_n=FF.
    - Load hold counter = HOLD-1, go STROBE.
  - STROBE (HOLD cycles):
    - cs_n[region]=0, all other bits 1.
    - Decrement counter; at counter==0 go RECOVER.
  - RECOVER (1 cycle):
    - cs_n=FF, ack[owner]=1, grant cleared on exit.
    - ptr=(owner+1) mod NREQ, go IDLE.
- Latency: req sampled high at edge k.
  - grant visible after edge k.
  - cs_n low after edges k+1..k+HOLD.
  - ack high for the cycle after edge k+HOLD+1.
  - Total occupancy HOLD+2 cycles; next grant no earlier than 1 cycle after ack (IDLE cycle).
- Region and owner are latched at grant. sel or req changes during the transaction have no effect.
- req dropped before ack: transaction still completes and ack still pulses.
- en=0 in SETUP or STROBE:
  - cs_n forced FF from the next edge, no ack, go IDLE.
  - ptr unchanged, so the same requester wins first once en returns.
- en=0 in RECOVER: completes normally, with ack.
- en=0 in IDLE: no grant issued; pending reqs wait.
- Simultaneous requests: the lowest index at or above ptr wins. A requester re-asserting immediately after ack is not starved and waits its turn.
- A requester holding req continuously across ack gets a new transaction only when the scan reaches it again.
- HOLD=1: STROBE lasts exactly one cycle.
- Invariants:
  - grant is zero or one-hot.
  - cs_n has at most one zero bit, and only while grant!=0.
  - ack only coincides with RECOVER.

Test Plan:
1. Reset: assert reset 3 cycles with req=4'hF, en=1 -> grant=0, cs_n=FF, ack=0, busy=0 throughout; first grant one cycle after reset release goes to req0.
2. Single request: HOLD=2, req=4'b0100, sel[8:6]=3'd5, en=1 at edge 0.
   - grant=4'b0100 after edge 0; cs_n=8'hDF after edges 1-2; cs_n=FF and ack=4'b0100 after edge 3; busy low after edge 4.
3. Round-robin: req=4'hF held continuously -> grant sequence 0,1,2,3,0 with a 1-cycle IDLE gap between ack and next grant each time.
4. Abort: en dropped during the first STROBE cycle of requester 2 -> cs_n=FF the next cycle, no ack; on en re-assert, requester 2 is granted again before 3.
5. Latch check: change sel of owner from 3 to 6 mid-STROBE and drop req -> cs_n bit 3 stays low for full HOLD and ack still pulses.
6. Mid-operation reset during STROBE -> next cycle all outputs at reset values; ptr=0.

Source files
------------

// File: rtl/bus_select_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : bus_select_arbiter_if
// Brief  : Request/region/strobe bundle between the requesters and the
//          peripheral-select arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface bus_select_arbiter_if;
    logic        en;
    logic [3:0]  req;
    logic [11:0] sel;
    logic [3:0]  grant;
    logic [7:0]  cs_n;
    logic [3:0]  ack;
    logic        busy;

    modport master (output en, req, sel, input grant, cs_n, ack, busy);
    modport slave  (input en, req, sel, output grant, cs_n, ack, busy);
endinterface
`default_nettype wire

// File: rtl/bus_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module : bus_select_arbiter
// Brief  : Round-robin owner selection plus setup/strobe/recover timing for
//          the shared active-low 3-to-8 peripheral select.
// Rev    : 1.0  initial release
// ============================================================================
module bus_select_arbiter #(
    parameter int NREQ = 4,
    parameter int HOLD = 2
) (
    input  wire logic           clk,
    input  wire logic           reset,
    bus_select_arbiter_if.slave bus
);

    localparam logic [1:0] c_idle      = 2'd0;
    localparam logic [1:0] c_setup     = 2'd1;
    localparam logic [1:0] c_strobe    = 2'd2;
    localparam logic [1:0] c_recover   = 2'd3;
    localparam logic [3:0] c_hold_load = 4'(HOLD - 1);
    localparam logic [1:0] c_last_req  = 2'(NREQ - 1);

    logic [1:0] r_state;
    logic [1:0] r_owner;
    logic [2:0] r_region;
    logic [3:0] r_cnt;
    logic [1:0] r_ptr;
    logic [3:0] r_grant;
    logic [7:0] r_cs_n;
    logic [3:0] r_ack;
    logic       r_busy;

    logic       w_found;
    logic [1:0] w_pick;
    logic [2:0] w_idx;
    logic [2:0] w_pick_region;

    function automatic logic [3:0] f_onehot(input logic [1:0] idx);
        f_onehot = 4'b0001 << idx;
    endfunction

    // Scan from the round-robin pointer upward, wrapping at NREQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        w_idx   = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = {1'b0, r_ptr} + 3'(k);
            if (w_idx >= 3'(NREQ)) begin
                w_idx = w_idx - 3'(NREQ);
            end
            if (!w_found && bus.req[w_idx[1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[1:0];
            end
        end
    end

    always_comb begin
        w_pick_region = bus.sel[2:0];
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick == 2'(i)) begin
                w_pick_region = bus.sel[3*i +: 3];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_idle;
            r_owner  <= 2'd0;
            r_region <= 3'd0;
            r_cnt    <= 4'd0;
            r_ptr    <= 2'd0;
            r_grant  <= 4'd0;
            r_cs_n   <= 8'hFF;
            r_ack    <= 4'd0;
            r_busy   <= 1'b0;
        end else begin
            r_ack <= 4'd0;
            case (r_state)
                c_idle: begin
                    if (bus.en && w_found) begin
                        r_owner  <= w_pick;
                        r_region <= w_pick_region;
                        r_grant  <= f_onehot(w_pick);
                        r_busy   <= 1'b1;
                        r_state  <= c_setup;
                    end
                end
                c_setup: begin
                    // Losing enable aborts without moving the pointer, so the
                    // same requester wins again once enable returns.
                    if (!bus.en) begin
                        r_grant <= 4'd0;
                        r_busy  <= 1'b0;
                        r_state <= c_idle;
                    end else begin
                        r_cnt   <= c_hold_load;
                        r_cs_n  <= ~(8'h01 << r_region);
                        r_state <= c_strobe;
                    end
                end
                c_strobe: begin
                    if (!bus.en) begin
                        r_cs_n  <= 8'hFF;
                        r_grant <= 4'd0;
                        r_busy  <= 1'b0;
                        r_state <= c_idle;
                    end else if (r_cnt == 4'd0) begin
                        r_cs_n  <= 8'hFF;
                        r_ack   <= r_grant;
                        r_state <= c_recover;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_recover: begin
                    r_grant <= 4'd0;
                    r_busy  <= 1'b0;
                    r_ptr   <= (r_owner == c_last_req) ? 2'd0 : r_owner + 2'd1;
                    r_state <= c_idle;
                end
                default: begin
                    r_grant <= 4'd0;
                    r_cs_n  <= 8'hFF;
                    r_busy  <= 1'b0;
                    r_state <= c_idle;
                end
            endcase
        end
    end

    assign bus.grant = r_grant;
    assign bus.cs_n  = r_cs_n;
    assign bus.ack   = r_ack;
    assign bus.busy  = r_busy;

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (reset)
        $onehot0(r_grant));
    a_cs_single : assert property (@(posedge clk) disable iff (reset)
        $onehot0(~r_cs_n) && ((r_cs_n == 8'hFF) || (r_grant != 4'd0)));
    a_ack_recover : assert property (@(posedge clk) disable iff (reset)
        (r_ack != 4'd0) |-> (r_state == c_recover));

endmodule
`default_nettype wire

// File: tb/tb_bus_select_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_bus_select_arbiter
// Brief  : Directed stimulus with a transaction scoreboard for the arbiter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bus_select_arbiter;

    localparam int HOLD = 2;

    logic clk = 1'b0;
    logic reset;

    bus_select_arbiter_if bif();

    bus_select_arbiter #(.NREQ(4), .HOLD(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int owner;
        int region;
        bit done;
        int gap;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   checks       = 0;
    int   failures     = 0;
    int   cyc          = 0;
    int   last_ack_cyc = -100;
    int   strobes      = 0;
    bit   in_txn       = 1'b0;
    bit   ack_seen     = 1'b0;

    function automatic logic [3:0] oh(input int i);
        oh = 4'b0001 << i;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int o, input bit done, input int gap);
        exp_t e;
        e.owner  = o;
        e.region = int'(bif.sel[3*o +: 3]);
        e.done   = done;
        e.gap    = gap;
        q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, bif.grant, 4'h0);
        chk({tag, "_cs_n"},  bif.cs_n,  8'hFF);
        chk({tag, "_ack"},   bif.ack,   4'h0);
        chk({tag, "_busy"},  bif.busy,  1'b0);
    endtask

    task automatic wait_q_empty();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("wait_grant_timeout", q.size(), 0);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bif.busy || in_txn) && n < 60);
        chk("wait_idle_timeout", {bif.busy, in_txn}, 2'b00);
    endtask

    task automatic wait_strobe();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bif.cs_n == 8'hFF && n < 20);
        chk("wait_strobe_timeout", (bif.cs_n != 8'hFF), 1'b1);
    endtask

    // Monitor: each new grant opens a transaction from the queue; cs_n,
    // ack and the closing of grant are judged against that entry.
    always @(negedge clk) begin
        logic [7:0] exp_cs;
        cyc++;
        if (!in_txn) begin
            if (bif.ack != 4'h0)   chk("ack_outside_txn", bif.ack, 4'h0);
            if (bif.cs_n != 8'hFF) chk("cs_outside_txn", bif.cs_n, 8'hFF);
            if (bif.grant != 4'h0) begin
                if (q.size() == 0) begin
                    chk("unexpected_grant", bif.grant, 4'h0);
                end else begin
                    cur = q.pop_front();
                    chk("grant_owner", bif.grant, oh(cur.owner));
                    if (cur.gap > 0) chk("grant_gap", cyc - last_ack_cyc, cur.gap);
                    in_txn   = 1'b1;
                    ack_seen = 1'b0;
                    strobes  = 0;
                end
            end
        end else begin
            if (bif.cs_n != 8'hFF) begin
                strobes++;
                exp_cs = ~(8'h01 << cur.region);
                chk("cs_region", bif.cs_n, exp_cs);
            end
            if (bif.ack != 4'h0) begin
                ack_seen     = 1'b1;
                last_ack_cyc = cyc;
                chk("ack_owner", bif.ack, oh(cur.owner));
                chk("ack_on_abort", cur.done, 1'b1);
                chk("strobe_len", strobes, HOLD);
            end
            if (bif.grant == 4'h0) begin
                if (!ack_seen) chk("abort_without_ack", cur.done, 1'b0);
                in_txn = 1'b0;
            end else if (bif.grant != oh(cur.owner)) begin
                chk("grant_stable", bif.grant, oh(cur.owner));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] grant;
        logic [7:0] cs_n;
        logic [3:0] ack;
        logic       busy;
    } row_t;

    row_t single_tbl[5];

    initial begin
        single_tbl[0] = '{4'b0100, 8'hFF, 4'b0000, 1'b1};
        single_tbl[1] = '{4'b0100, 8'hDF, 4'b0000, 1'b1};
        single_tbl[2] = '{4'b0100, 8'hDF, 4'b0000, 1'b1};
        single_tbl[3] = '{4'b0100, 8'hFF, 4'b0100, 1'b1};
        single_tbl[4] = '{4'b0000, 8'hFF, 4'b0000, 1'b0};

        // Reset held with every requester asking, then full round-robin
        reset   = 1'b1;
        bif.en  = 1'b1;
        bif.req = 4'hF;
        bif.sel = {3'd7, 3'd2, 3'd5, 3'd1};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset_outputs("reset_hold");
        end
        push(0, 1'b1, 0);
        push(1, 1'b1, 2);
        push(2, 1'b1, 2);
        push(3, 1'b1, 2);
        push(0, 1'b1, 2);
        reset = 1'b0;
        @(negedge clk);
        chk("first_grant_after_reset", bif.grant, 4'b0001);
        wait_q_empty();
        bif.req = 4'h0;
        wait_idle();

        // Single request, cycle-exact timing
        bif.sel[8:6] = 3'd5;
        bif.req      = 4'b0100;
        push(2, 1'b1, 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("single_grant_c%0d", c), bif.grant, single_tbl[c].grant);
            chk($sformatf("single_cs_c%0d", c),    bif.cs_n,  single_tbl[c].cs_n);
            chk($sformatf("single_ack_c%0d", c),   bif.ack,   single_tbl[c].ack);
            chk($sformatf("single_busy_c%0d", c),  bif.busy,  single_tbl[c].busy);
            if (c == 0) bif.req = 4'h0;
        end
        wait_idle();

        // Move the pointer to 2, then abort requester 2 mid-strobe
        bif.req = 4'b0010;
        push(1, 1'b1, 0);
        wait_q_empty();
        bif.req = 4'h0;
        wait_idle();

        bif.req = 4'b1100;
        push(2, 1'b0, 0);
        push(2, 1'b1, 0);
        push(3, 1'b1, 2);
        @(negedge clk);
        @(negedge clk);
        bif.en = 1'b0;
        @(negedge clk);
        chk("abort_cs_n",  bif.cs_n,  8'hFF);
        chk("abort_grant", bif.grant, 4'h0);
        chk("abort_ack",   bif.ack,   4'h0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("en_low_no_grant", bif.grant, 4'h0);
        end
        bif.en = 1'b1;
        wait_q_empty();
        bif.req = 4'h0;
        wait_idle();

        // Region latched at grant: sel and req change mid-strobe
        bif.sel[2:0] = 3'd3;
        bif.req      = 4'b0001;
        push(0, 1'b1, 0);
        wait_strobe();
        bif.sel[2:0] = 3'd6;
        bif.req      = 4'h0;
        wait_idle();

        // Reset during strobe, then pointer must be back at 0
        bif.sel[5:3] = 3'd4;
        bif.req      = 4'b0010;
        push(1, 1'b0, 0);
        wait_strobe();
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("mid_reset");
        bif.req = 4'b0011;
        push(0, 1'b1, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ptr_reset_grant", bif.grant, 4'b0001);
        bif.req = 4'h0;
        wait_idle();

        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
